fp_cmp_arbiter: RTL and testbench

//   Shares one combinational FP compare unit (EQ/LT/LE, single precision) among
//   NUM_REQ requesters. Round-robin arbitration, valid/ready request and response

---
 rtl/fp_cmp_arbiter.sv | 169 ++++++++++++++++
 tb/tb_fp_cmp_arbiter.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_cmp_arbiter.sv
// fp_cmp_arbiter
//   Shares one combinational single-precision FP compare unit (EQ/LT/LE) among
//   NUM_REQ requesters. Round-robin grant, valid/ready on both request and
//   response sides, registered operands and registered results.
//
//   Ports
//     in_clk, in_rst_n             clock (rising edge), async active-low reset
//     in_req_valid/out_req_ready   per-requester request handshake (ready one-hot)
//     in_req_numA/numB/type        packed per-requester operands, requester i at [i*W +: W]
//     out_cmp_numA/numB/type       operand/type registers feeding the compare unit
//     in_cmp_data/in_cmp_nv        compare unit result and invalid-operation flag
//     out_rsp_valid/in_rsp_ready   response handshake
//     out_rsp_id/data/nv           owner index, registered result, registered NV
//
//   Build option FP_CMP_STICKY_NV_EN adds in_fflag_clr / out_fflag_nv, a sticky
//   NV flag set on every response handshake that carries NV=1.
module fp_cmp_arbiter #(
  parameter  int DATA_WIDTH = 32,
  parameter  int NUM_REQ    = 2,
  localparam int IDW        = $clog2(NUM_REQ)
) (
  input  logic                          in_clk,
  input  logic                          in_rst_n,
  input  logic [NUM_REQ-1:0]            in_req_valid,
  output logic [NUM_REQ-1:0]            out_req_ready,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] in_req_numA,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] in_req_numB,
  input  logic [NUM_REQ*2-1:0]          in_req_type,
  output logic [DATA_WIDTH-1:0]         out_cmp_numA,
  output logic [DATA_WIDTH-1:0]         out_cmp_numB,
  output logic [1:0]                    out_cmp_type,
  input  logic [DATA_WIDTH-1:0]         in_cmp_data,
  input  logic                          in_cmp_nv,
`ifdef FP_CMP_STICKY_NV_EN
  input  logic                          in_fflag_clr,
  output logic                          out_fflag_nv,
`endif
  output logic                          out_rsp_valid,
  input  logic                          in_rsp_ready,
  output logic [IDW-1:0]                out_rsp_id,
  output logic [DATA_WIDTH-1:0]         out_rsp_data,
  output logic                          out_rsp_nv
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  localparam logic [IDW:0]   NREQ_W = (IDW+1)'(NUM_REQ);
  localparam logic [IDW-1:0] LAST   = IDW'(NUM_REQ-1);

  state_t                  state_q, state_d;
  logic [IDW-1:0]          rr_q, rr_d;
  logic [DATA_WIDTH-1:0]   a_q, a_d, b_q, b_d, data_q, data_d;
  logic [1:0]              type_q, type_d;
  logic [IDW-1:0]          id_q, id_d;
  logic                    nv_q, nv_d;

  // Packed views of the flat request buses, one row per requester.
  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] req_a, req_b;
  logic [NUM_REQ-1:0][1:0]            req_t;
  assign req_a = in_req_numA;
  assign req_b = in_req_numB;
  assign req_t = in_req_type;

  // Round-robin search: first valid requester at or after rr_q, with wrap.
  logic           gnt_found;
  logic [IDW-1:0] gnt_idx;
  logic [IDW:0]   scan;
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    scan      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan = {1'b0, rr_q} + (IDW+1)'(k);
      if (scan >= NREQ_W) scan = scan - NREQ_W;
      if (!gnt_found && in_req_valid[scan[IDW-1:0]]) begin
        gnt_found = 1'b1;
        gnt_idx   = scan[IDW-1:0];
      end
    end
  end

  // Ready is gated by reset so no requester sees an accept while held in reset.
  logic [NUM_REQ-1:0] gnt_oh;
  always_comb begin
    gnt_oh          = '0;
    gnt_oh[gnt_idx] = gnt_found;
    out_req_ready   = (state_q == IDLE && in_rst_n) ? gnt_oh : '0;
  end

  logic rsp_hs;
  assign rsp_hs = (state_q == RESP) && in_rsp_ready;

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    a_d     = a_q;
    b_d     = b_q;
    type_d  = type_q;
    id_d    = id_q;
    data_d  = data_q;
    nv_d    = nv_q;
    unique case (state_q)
      IDLE: if (gnt_found) begin
        a_d     = req_a[gnt_idx];
        b_d     = req_b[gnt_idx];
        type_d  = req_t[gnt_idx];
        id_d    = gnt_idx;
        rr_d    = (gnt_idx == LAST) ? '0 : gnt_idx + 1'b1;
        state_d = EXEC;
      end
      EXEC: begin
        data_d  = in_cmp_data;
        nv_d    = in_cmp_nv;
        state_d = RESP;
      end
      RESP: if (in_rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      state_q <= IDLE;
      rr_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      type_q  <= '0;
      id_q    <= '0;
      data_q  <= '0;
      nv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      a_q     <= a_d;
      b_q     <= b_d;
      type_q  <= type_d;
      id_q    <= id_d;
      data_q  <= data_d;
      nv_q    <= nv_d;
    end
  end

  assign out_cmp_numA  = a_q;
  assign out_cmp_numB  = b_q;
  assign out_cmp_type  = type_q;
  assign out_rsp_valid = (state_q == RESP);
  assign out_rsp_id    = id_q;
  assign out_rsp_data  = data_q;
  assign out_rsp_nv    = nv_q;

`ifdef FP_CMP_STICKY_NV_EN
  // Set takes priority over clear so an NV landing on the clear cycle is kept.
  logic fflag_q, fflag_d;
  always_comb begin
    fflag_d = fflag_q;
    if (rsp_hs && nv_q)     fflag_d = 1'b1;
    else if (in_fflag_clr)  fflag_d = 1'b0;
  end
  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) fflag_q <= 1'b0;
    else           fflag_q <= fflag_d;
  end
  assign out_fflag_nv = fflag_q;
`else
  logic unused_hs;
  assign unused_hs = rsp_hs;
`endif

endmodule

// File: tb/tb_fp_cmp_arbiter.sv
module tb_fp_cmp_arbiter;
  localparam int N   = 2;
  localparam int DW  = 32;
  localparam int IDW = $clog2(N);

  logic                  in_clk, in_rst_n;
  logic [N-1:0]          st_v;
  logic [N-1:0][DW-1:0]  st_a, st_b;
  logic [N-1:0][1:0]     st_t;
  logic                  rsp_rdy, fclr;
  logic [N-1:0]          out_req_ready;
  logic [DW-1:0]         out_cmp_numA, out_cmp_numB, in_cmp_data, out_rsp_data;
  logic [1:0]            out_cmp_type;
  logic                  in_cmp_nv, out_rsp_valid, out_rsp_nv;
  logic [IDW-1:0]        out_rsp_id;
`ifdef FP_CMP_STICKY_NV_EN
  logic                  out_fflag_nv;
`endif

  fp_cmp_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(N)) dut (
    .in_clk(in_clk), .in_rst_n(in_rst_n),
    .in_req_valid(st_v), .out_req_ready(out_req_ready),
    .in_req_numA(st_a), .in_req_numB(st_b), .in_req_type(st_t),
    .out_cmp_numA(out_cmp_numA), .out_cmp_numB(out_cmp_numB), .out_cmp_type(out_cmp_type),
    .in_cmp_data(in_cmp_data), .in_cmp_nv(in_cmp_nv),
`ifdef FP_CMP_STICKY_NV_EN
    .in_fflag_clr(fclr), .out_fflag_nv(out_fflag_nv),
`endif
    .out_rsp_valid(out_rsp_valid), .in_rsp_ready(rsp_rdy),
    .out_rsp_id(out_rsp_id), .out_rsp_data(out_rsp_data), .out_rsp_nv(out_rsp_nv)
  );

  initial in_clk = 1'b0;
  always #5 in_clk = ~in_clk;

  // Stand-in compare unit: bit-level IEEE-754 single-precision compare.
  function automatic logic [1:0] unit_f(logic [31:0] a, logic [31:0] b, logic [1:0] t);
    logic na, nb, z, eq, lt, r;
    na = (a[30:23] == 8'hFF) && (a[22:0] != 0);
    nb = (b[30:23] == 8'hFF) && (b[22:0] != 0);
    z  = (a[30:0] == 0) && (b[30:0] == 0);
    eq = !(na || nb) && ((a == b) || z);
    if (na || nb || z)      lt = 1'b0;
    else if (a[31] != b[31]) lt = a[31];
    else if (!a[31])         lt = a[30:0] < b[30:0];
    else                     lt = a[30:0] > b[30:0];
    case (t)
      2'b10:   r = eq;
      2'b01:   r = lt;
      2'b00:   r = lt | eq;
      default: r = 1'b0;
    endcase
    return {na | nb, r};
  endfunction

  always_comb begin
    logic [1:0] u;
    u           = unit_f(out_cmp_numA, out_cmp_numB, out_cmp_type);
    in_cmp_nv   = u[1];
    in_cmp_data = {31'b0, u[0]};
  end

  // Reference model: operands decoded to real numbers and compared arithmetically.
  function automatic real fval(logic [31:0] x);
    int  e;
    real r;
    e = int'(x[30:23]);
    if (e == 255)    r = 1.0e300;
    else if (e == 0) r = real'(x[22:0]) * (2.0 ** -149);
    else             r = (real'(x[22:0]) + 8388608.0) * (2.0 ** (e - 150));
    return x[31] ? -r : r;
  endfunction

  function automatic logic [1:0] ref_cmp(logic [31:0] a, logic [31:0] b, logic [1:0] t);
    logic nan;
    real  ra, rb;
    logic r;
    nan = ((a[30:23] == 8'hFF) && (a[22:0] != 0)) || ((b[30:23] == 8'hFF) && (b[22:0] != 0));
    ra  = fval(a);
    rb  = fval(b);
    if (nan) r = 1'b0;
    else case (t)
      2'b10:   r = (ra == rb);
      2'b01:   r = (ra < rb);
      2'b00:   r = (ra <= rb);
      default: r = 1'b0;
    endcase
    return {nan, r};
  endfunction

  int n_chk = 0, n_pass = 0;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
  endtask

  // Model state
  int         m_rr = 0, m_age = 0, m_id = 0;
  bit         m_busy = 0, m_sticky = 0;
  logic [1:0] m_res = '0;
  bit         refresh [N];

  // One clock cycle: inputs already applied; check at negedge, advance model at posedge.
  task automatic cyc();
    int g, idx;
    bit any, acc, hs, clr_s;
    logic [N-1:0] exp_rdy;
    logic [1:0]   r;
    @(negedge in_clk);
    any = 0; g = 0;
    for (int k = 0; k < N; k++) begin
      idx = (m_rr + k) % N;
      if (!any && st_v[idx]) begin any = 1; g = idx; end
    end
    exp_rdy = '0;
    if (!m_busy && any) exp_rdy[g] = 1'b1;
    chk("req_ready", 64'(out_req_ready), 64'(exp_rdy));
    chk("rsp_valid", 64'(out_rsp_valid), 64'(m_busy && m_age >= 2));
    if (m_busy && m_age >= 2) begin
      chk("rsp_id",   64'(out_rsp_id),   64'(m_id));
      chk("rsp_data", 64'(out_rsp_data), 64'(m_res[0]));
      chk("rsp_nv",   64'(out_rsp_nv),   64'(m_res[1]));
    end
`ifdef FP_CMP_STICKY_NV_EN
    chk("fflag_nv", 64'(out_fflag_nv), 64'(m_sticky));
`endif
    acc   = !m_busy && any;
    hs    = m_busy && m_age >= 2 && rsp_rdy;
    clr_s = fclr;
    r     = ref_cmp(st_a[g], st_b[g], st_t[g]);
    @(posedge in_clk);
    #1;
    if (hs && m_res[1])  m_sticky = 1;
    else if (clr_s)      m_sticky = 0;
    if (acc) begin
      m_busy = 1; m_age = 1; m_id = g; m_res = r;
      m_rr = (g + 1) % N; refresh[g] = 1;
    end else if (m_busy) begin
      if (hs) m_busy = 0;
      else if (m_age < 2) m_age++;
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  // Called at posedge+1; reset pulse ends before the next negedge check.
  task automatic do_reset();
    in_rst_n = 1'b0;
    #2;
    chk("rst_req_ready", 64'(out_req_ready), 64'(0));
    chk("rst_rsp_valid", 64'(out_rsp_valid), 64'(0));
    chk("rst_rsp_id",    64'(out_rsp_id),    64'(0));
    chk("rst_rsp_data",  64'(out_rsp_data),  64'(0));
    chk("rst_rsp_nv",    64'(out_rsp_nv),    64'(0));
    chk("rst_cmp_a",     64'(out_cmp_numA),  64'(0));
    chk("rst_cmp_b",     64'(out_cmp_numB),  64'(0));
    chk("rst_cmp_t",     64'(out_cmp_type),  64'(0));
`ifdef FP_CMP_STICKY_NV_EN
    chk("rst_fflag",     64'(out_fflag_nv),  64'(0));
`endif
    #1;
    in_rst_n = 1'b1;
    m_rr = 0; m_busy = 0; m_age = 0; m_sticky = 0;
  endtask

  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b, input logic [1:0] t);
    st_v[i] = 1'b1; st_a[i] = a; st_b[i] = b; st_t[i] = t;
  endtask

  // Single request from requester i, dropped after accept, answered with ready=1.
  task automatic op(input int i, input logic [31:0] a, input logic [31:0] b, input logic [1:0] t);
    set_req(i, a, b, t);
    cyc();
    st_v[i] = 1'b0;
    run(3);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 8))
      0: return 32'h3F800000;
      1: return 32'h40000000;
      2: return 32'hC0400000;
      3: return 32'h00000000;
      4: return 32'h80000000;
      5: return 32'h7FC00000;
      6: return 32'h7F800000;
      7: return 32'h00000001;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    in_rst_n = 1'b0;
    st_v = '1; st_a = '0; st_b = '0; st_t = '0;
    rsp_rdy = 1'b1; fclr = 1'b0;
    for (int i = 0; i < N; i++) refresh[i] = 0;
    @(posedge in_clk); #1;
    do_reset();
    st_v = '0;

    // Basic ops: LT, EQ, LE
    op(0, 32'h3F800000, 32'h40000000, 2'b01);
    op(1, 32'hC0400000, 32'hC0400000, 2'b10);
    op(1, 32'h40000000, 32'h3F800000, 2'b00);
    // Reserved type is forwarded
    op(0, 32'h3F800000, 32'h3F800000, 2'b11);

    // Both requesters held valid: grants alternate
    set_req(0, 32'h3F800000, 32'h40000000, 2'b01);
    set_req(1, 32'h40000000, 32'h3F800000, 2'b01);
    run(12);
    st_v = '0;
    run(3);

    // NaN: NV per response, sticky flag until cleared
    op(0, 32'hFFC00000, 32'h3F800000, 2'b10);
    run(3);
    fclr = 1'b1; cyc(); fclr = 1'b0;
    run(2);

    // Response backpressure for 5 cycles, then accept resumes 1 cycle after handshake
    rsp_rdy = 1'b0;
    set_req(0, 32'hC0400000, 32'h3F800000, 2'b00);
    cyc();
    st_v[0] = 1'b0;
    set_req(1, 32'h3F800000, 32'h3F800000, 2'b10);
    run(6);
    rsp_rdy = 1'b1;
    run(2);
    st_v = '0;
    run(3);

    // Reset during EXEC: no response, restart arbitration from requester 0
    set_req(0, 32'h3F800000, 32'h40000000, 2'b01);
    cyc();
    st_v = '0;
    do_reset();
    set_req(0, 32'h40000000, 32'h40000000, 2'b10);
    set_req(1, 32'h40000000, 32'h3F800000, 2'b00);
    run(4);
    st_v = '0;
    run(3);

    // Randomized traffic
    for (int i = 0; i < N; i++) refresh[i] = 0;
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!st_v[i] || refresh[i]) begin
          if ($urandom_range(0, 2) != 0) set_req(i, pick(), pick(), 2'($urandom_range(0, 3)));
          else st_v[i] = 1'b0;
          refresh[i] = 0;
        end else if ($urandom_range(0, 15) == 0) begin
          st_v[i] = 1'b0;
        end
      end
      rsp_rdy = ($urandom_range(0, 3) != 0);
      fclr    = ($urandom_range(0, 7) == 0);
      cyc();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
